// File: rtl/rf_write_arbiter.sv
// ----------------------------------------------------------------------------
// rf_write_arbiter
//
// Shares the single register-file write port among NREQ writeback sources
// (e.g. 0=ALU, 1=load unit, 2=mul/div) using round-robin arbitration.
// One write per cycle is accepted through a valid/ready handshake and
// registered into an output stage. That stage feeds the register file's
// we/writeRegister/writeData pins directly.
//
// Parameters
//   NREQ  number of requesters (2..8)
//   AW    register address width
//   DW    data width
//
// Ports
//   clk        in   1        clock, all state updates on posedge
//   rst        in   1        asynchronous active-low reset
//   hold       in   1        1 = accept nothing this cycle (pipeline freeze)
//   req_valid  in   NREQ     per-requester write request
//   req_addr   in   NREQ*AW  destination register, requester i at [i*AW +: AW]
//   req_data   in   NREQ*DW  write data, requester i at [i*DW +: DW]
//   req_ready  out  NREQ     one-hot grant, transfer = valid & ready
//   rf_we      out  1        register-file write enable (registered)
//   rf_waddr   out  AW       register-file write address (registered)
//   rf_wdata   out  DW       register-file write data (registered)
//   grant_id   out  3        requester index held in the output stage
//   busy       out  1        any request pending or a write in flight
// ----------------------------------------------------------------------------
module rf_write_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hold,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               rf_we,
  output logic [AW-1:0]      rf_waddr,
  output logic [DW-1:0]      rf_wdata,
  output logic [2:0]         grant_id,
  output logic               busy
);

  // Index of the most recently granted requester; the scan starts just past it.
  logic [2:0]    last;
  logic [2:0]    win;
  logic          found;
  logic          transfer;
  logic [3:0]    scan_idx;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;

  // Round-robin scan: last+1, last+2, ... modulo NREQ, first valid wins.
  // NOTE: every variable assigned in always_comb gets a default at the top so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    scan_idx = '0;
    for (int i = 1; i <= NREQ; i++) begin
      // last <= 7 and i <= 8, so one conditional subtract gives the modulo.
      scan_idx = {1'b0, last} + 4'(i);
      if (scan_idx >= 4'(NREQ)) scan_idx = scan_idx - 4'(NREQ);
      for (int j = 0; j < NREQ; j++) begin
        if (!found && (4'(j) == scan_idx) && req_valid[j]) begin
          found = 1'b1;
          win   = 3'(j);
        end
      end
    end
  end

  // Grants are suppressed under hold and while reset is asserted, so nothing
  // upstream sees a handshake the output stage cannot capture.
  assign transfer = found & ~hold & rst;

  always_comb begin
    req_ready = '0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (3'(i) == win) begin
        req_ready[i] = transfer;
        sel_addr     = req_addr[i*AW +: AW];
        sel_data     = req_data[i*DW +: DW];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      grant_id <= '0;
      last     <= 3'(NREQ - 1);
    end else begin
      rf_we <= 1'b0;
      if (transfer) begin
        // A write to r0 completes the handshake but never reaches the file.
        rf_we    <= (sel_addr != '0);
        rf_waddr <= sel_addr;
        rf_wdata <= sel_data;
        grant_id <= win;
        last     <= win;
      end
    end
  end

  assign busy = (|req_valid) | rf_we;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rf_write_arbiter
//
// Directed bench for rf_write_arbiter (NREQ=3, AW=5, DW=32). Inputs change
// 1 time unit after a posedge. Combinational grants are sampled before the
// next edge, and registered outputs are sampled 1 time unit after an edge.
// ----------------------------------------------------------------------------
module tb_rf_write_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic            clk;
  logic            rst;
  logic            hold;
  logic [NREQ-1:0] req_valid;
  logic [AW-1:0]   a [NREQ];
  logic [DW-1:0]   d [NREQ];
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0] req_ready;
  logic            rf_we;
  logic [AW-1:0]   rf_waddr;
  logic [DW-1:0]   rf_wdata;
  logic [2:0]      grant_id;
  logic            busy;

  int tests_run    = 0;
  int tests_failed = 0;

  assign req_addr = {a[2], a[1], a[0]};
  assign req_data = {d[2], d[1], d[0]};

  rf_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .hold      (hold),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Brings the arbiter back to its reset state (pointer = NREQ-1).
  task automatic apply_reset();
    req_valid = '0;
    hold      = 1'b0;
    rst       = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    hold      = 1'b0;
    req_valid = 3'b111;
    a[0] = 5'd3; d[0] = 32'h0000_0011;
    a[1] = 5'd4; d[1] = 32'h0000_0022;
    a[2] = 5'd6; d[2] = 32'h0000_0033;
    #1;
    tests_run++;
    if (req_ready !== 3'b000) begin
      tests_failed++; $display("FAIL reset_ready: got %b want 000", req_ready);
    end
    tests_run++;
    if ({rf_we, rf_waddr, rf_wdata, grant_id} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got we=%b addr=%0d data=%h id=%0d want all 0",
               rf_we, rf_waddr, rf_wdata, grant_id);
    end
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++; $display("FAIL reset_busy: got %b want 1", busy);
    end
    tick();
    tests_run++;
    if (rf_we !== 1'b0) begin
      tests_failed++; $display("FAIL reset_edge_we: got %b want 0", rf_we);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (req_ready !== 3'b001) begin
      tests_failed++; $display("FAIL reset_first_grant: got %b want 001", req_ready);
    end
    tick();
    req_valid = '0;
    tests_run++;
    if ({rf_we, rf_waddr, rf_wdata, grant_id} !== {1'b1, 5'd3, 32'h0000_0011, 3'd0}) begin
      tests_failed++;
      $display("FAIL reset_first_write: got we=%b addr=%0d data=%h id=%0d want 1/3/00000011/0",
               rf_we, rf_waddr, rf_wdata, grant_id);
    end
  endtask

  task automatic test_single_write();
    apply_reset();
    req_valid = 3'b010;
    a[1] = 5'd5; d[1] = 32'hDEAD_BEEF;
    #1;
    tests_run++;
    if (req_ready !== 3'b010) begin
      tests_failed++; $display("FAIL single_ready: got %b want 010", req_ready);
    end
    tick();
    req_valid = '0;
    tests_run++;
    if ({rf_we, rf_waddr, rf_wdata, grant_id} !== {1'b1, 5'd5, 32'hDEAD_BEEF, 3'd1}) begin
      tests_failed++;
      $display("FAIL single_write: got we=%b addr=%0d data=%h id=%0d want 1/5/deadbeef/1",
               rf_we, rf_waddr, rf_wdata, grant_id);
    end
    tick();
    tests_run++;
    if ({rf_we, rf_waddr, rf_wdata, grant_id, busy} !== {1'b0, 5'd5, 32'hDEAD_BEEF, 3'd1, 1'b0}) begin
      tests_failed++;
      $display("FAIL single_idle_hold: got we=%b addr=%0d data=%h id=%0d busy=%b want 0/5/deadbeef/1/0",
               rf_we, rf_waddr, rf_wdata, grant_id, busy);
    end
  endtask

  task automatic test_fairness();
    logic [NREQ-1:0] exp_ready;
    apply_reset();
    for (int i = 0; i < NREQ; i++) begin
      a[i] = AW'(i + 1);
      d[i] = 32'h100 + DW'(i);
    end
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      exp_ready = 3'b001 << (k % 3);
      #1;
      tests_run++;
      if (req_ready !== exp_ready) begin
        tests_failed++;
        $display("FAIL fair_ready_%0d: got %b want %b", k, req_ready, exp_ready);
      end
      tick();
      tests_run++;
      if ({rf_we, grant_id, rf_waddr, rf_wdata} !==
          {1'b1, 3'(k % 3), 5'(k % 3 + 1), 32'h100 + 32'(k % 3)}) begin
        tests_failed++;
        $display("FAIL fair_write_%0d: got we=%b id=%0d addr=%0d data=%h want id=%0d",
                 k, rf_we, grant_id, rf_waddr, rf_wdata, k % 3);
      end
    end
    req_valid = '0;
    tick();
    tests_run++;
    if (rf_we !== 1'b0) begin
      tests_failed++; $display("FAIL fair_drain: got we=%b want 0", rf_we);
    end
  endtask

  task automatic test_r0_write();
    apply_reset();
    // Move the pointer to 1 first so the r0 write is what moves it to 2.
    req_valid = 3'b010;
    a[1] = 5'd9; d[1] = 32'h0000_0099;
    tick();
    req_valid = 3'b100;
    a[2] = 5'd0; d[2] = 32'h0000_0007;
    #1;
    tests_run++;
    if (req_ready !== 3'b100) begin
      tests_failed++; $display("FAIL r0_ready: got %b want 100", req_ready);
    end
    tick();
    tests_run++;
    if ({rf_we, rf_waddr, rf_wdata, grant_id} !== {1'b0, 5'd0, 32'h0000_0007, 3'd2}) begin
      tests_failed++;
      $display("FAIL r0_no_write: got we=%b addr=%0d data=%h id=%0d want 0/0/00000007/2",
               rf_we, rf_waddr, rf_wdata, grant_id);
    end
    // Pointer is now 2: a full tie goes to requester 0 (would be 2 if it stayed at 1).
    req_valid = 3'b111;
    #1;
    tests_run++;
    if (req_ready !== 3'b001) begin
      tests_failed++; $display("FAIL r0_pointer_advance: got %b want 001", req_ready);
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_hold();
    apply_reset();
    a[0] = 5'd10; d[0] = 32'hA0A0_A0A0;
    a[1] = 5'd11; d[1] = 32'hB1B1_B1B1;
    a[2] = 5'd12; d[2] = 32'hC2C2_C2C2;
    req_valid = 3'b010;
    tick();                       // req1 transferred, pointer = 1
    hold      = 1'b1;
    req_valid = 3'b101;
    #1;
    tests_run++;
    if ({rf_we, rf_waddr} !== {1'b1, 5'd11}) begin
      tests_failed++;
      $display("FAIL hold_issued_completes: got we=%b addr=%0d want 1/11", rf_we, rf_waddr);
    end
    for (int c = 0; c < 2; c++) begin
      tests_run++;
      if (req_ready !== 3'b000) begin
        tests_failed++; $display("FAIL hold_ready_%0d: got %b want 000", c, req_ready);
      end
      tick();
      tests_run++;
      if (rf_we !== 1'b0) begin
        tests_failed++; $display("FAIL hold_we_%0d: got %b want 0", c, rf_we);
      end
    end
    hold = 1'b0;
    #1;
    // Pointer still 1 after the held cycles, so requester 2 is scanned first.
    tests_run++;
    if (req_ready !== 3'b100) begin
      tests_failed++; $display("FAIL hold_release_ready: got %b want 100", req_ready);
    end
    tick();
    req_valid = 3'b001;
    tests_run++;
    if ({rf_we, rf_waddr, grant_id} !== {1'b1, 5'd12, 3'd2}) begin
      tests_failed++;
      $display("FAIL hold_release_write: got we=%b addr=%0d id=%0d want 1/12/2",
               rf_we, rf_waddr, grant_id);
    end
    #1;
    tests_run++;
    if (req_ready !== 3'b001) begin
      tests_failed++; $display("FAIL hold_req0_ready: got %b want 001", req_ready);
    end
    tick();
    req_valid = '0;
    tests_run++;
    if ({rf_we, rf_waddr, rf_wdata, grant_id} !== {1'b1, 5'd10, 32'hA0A0_A0A0, 3'd0}) begin
      tests_failed++;
      $display("FAIL hold_req0_write: got we=%b addr=%0d data=%h id=%0d want 1/10/a0a0a0a0/0",
               rf_we, rf_waddr, rf_wdata, grant_id);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    a[1] = 5'd20; d[1] = 32'h1234_5678;
    a[0] = 5'd21; d[0] = 32'h8765_4321;
    req_valid = 3'b010;
    tick();                       // rf_we high for req1's write
    req_valid = 3'b001;           // req0 now waiting
    tests_run++;
    if (rf_we !== 1'b1) begin
      tests_failed++; $display("FAIL arst_pre_we: got %b want 1", rf_we);
    end
    #1;
    rst = 1'b0;                   // between edges, before the mid-cycle negedge
    #1;
    tests_run++;
    if ({rf_we, rf_waddr, rf_wdata, req_ready} !== '0) begin
      tests_failed++;
      $display("FAIL arst_immediate: got we=%b addr=%0d data=%h ready=%b want all 0",
               rf_we, rf_waddr, rf_wdata, req_ready);
    end
    @(negedge clk);
    tests_run++;
    if (rf_we !== 1'b0) begin
      tests_failed++; $display("FAIL arst_negedge_we: got %b want 0", rf_we);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    tests_run++;
    if (req_ready !== 3'b001) begin
      tests_failed++; $display("FAIL arst_represent_ready: got %b want 001", req_ready);
    end
    tick();
    req_valid = '0;
    tests_run++;
    if ({rf_we, rf_waddr, rf_wdata, grant_id} !== {1'b1, 5'd21, 32'h8765_4321, 3'd0}) begin
      tests_failed++;
      $display("FAIL arst_represent_write: got we=%b addr=%0d data=%h id=%0d want 1/21/87654321/0",
               rf_we, rf_waddr, rf_wdata, grant_id);
    end
  endtask

  initial begin
    rst       = 1'b0;
    hold      = 1'b0;
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      a[i] = '0;
      d[i] = '0;
    end
    #3;
    test_reset();
    test_single_write();
    test_fairness();
    test_r0_write();
    test_hold();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
